// File: rtl/text_renderer_pkg.sv
// Shared font geometry, coordinate widths, control codes and FSM state encoding
// for the text renderer and its glyph engine.
package text_renderer_pkg;

    localparam int FONT_WIDTH  = 5;
    localparam int FONT_HEIGHT = 7;
    localparam int CHAR_BITS   = 8;
    localparam int X_BITS      = 10;
    localparam int Y_BITS      = 9;
    localparam int ATTR_BITS   = 3;

    localparam logic [CHAR_BITS-1:0] CHAR_NEWLINE = 8'h0A;
    localparam logic [CHAR_BITS-1:0] CHAR_SPACE   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_DRAW,
        ST_RELEASE,
        ST_ADVANCE,
        ST_DONE
    } state_e;

    // Row bitmap, leftmost pixel in the MSB. Codes without a glyph render as a hollow box.
    function automatic logic [FONT_WIDTH-1:0] glyph_row(input logic [CHAR_BITS-1:0] ch,
                                                       input logic [2:0] row);
        logic [FONT_WIDTH-1:0] r;
        r = '0;
        case (ch)
            8'h41: begin
                case (row)
                    3'd0:                   r = 5'b01110;
                    3'd3:                   r = 5'b11111;
                    3'd1, 3'd2, 3'd4, 3'd5, 3'd6: r = 5'b10001;
                    default:                r = 5'b00000;
                endcase
            end
            8'h42: begin
                case (row)
                    3'd0, 3'd3, 3'd6:       r = 5'b11110;
                    3'd1, 3'd2, 3'd4, 3'd5: r = 5'b10001;
                    default:                r = 5'b00000;
                endcase
            end
            8'h43: begin
                case (row)
                    3'd0, 3'd6:             r = 5'b01110;
                    3'd1, 3'd5:             r = 5'b10001;
                    3'd2, 3'd3, 3'd4:       r = 5'b10000;
                    default:                r = 5'b00000;
                endcase
            end
            default: begin
                case (row)
                    3'd0, 3'd6:             r = 5'b11111;
                    3'd1, 3'd2, 3'd3, 3'd4, 3'd5: r = 5'b10001;
                    default:                r = 5'b00000;
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/text_renderer_character.sv
// Glyph engine: scans one character cell pixel by pixel at the given scale while
// enabled, and holds has_finished until enable drops, which also rewinds the scan.
module character_renderer
    import text_renderer_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [CHAR_BITS-1:0] char_i,
    input  logic [X_BITS-1:0]    x_i,
    input  logic [Y_BITS-1:0]    y_i,
    input  logic [ATTR_BITS-1:0] size_i,
    output logic [X_BITS-1:0]    out_x_o,
    output logic [Y_BITS-1:0]    out_y_o,
    output logic                 is_drawing_o,
    output logic                 has_finished_o
);

    logic [2:0]           col_q, row_q;
    logic [ATTR_BITS-1:0] sx_q, sy_q;
    logic [X_BITS-1:0]    x_q;
    logic [Y_BITS-1:0]    y_q;
    logic                 draw_q, fin_q;

    logic [ATTR_BITS-1:0]  size_eff;
    logic                  sx_last, sy_last, col_last, row_last;
    logic [FONT_WIDTH-1:0] font_row;
    logic                  pix_on;
    logic [X_BITS-1:0]     pix_x;
    logic [Y_BITS-1:0]     pix_y;

    // A zero scale is treated as 1 so the scan always terminates.
    assign size_eff = (size_i == '0) ? ATTR_BITS'(1) : size_i;
    assign sx_last  = (sx_q == size_eff - ATTR_BITS'(1));
    assign sy_last  = (sy_q == size_eff - ATTR_BITS'(1));
    assign col_last = (col_q == 3'(FONT_WIDTH - 1));
    assign row_last = (row_q == 3'(FONT_HEIGHT - 1));

    assign font_row = glyph_row(char_i, row_q);
    assign pix_on   = font_row[3'(FONT_WIDTH - 1) - col_q];
    assign pix_x    = x_i + X_BITS'(col_q) * X_BITS'(size_eff) + X_BITS'(sx_q);
    assign pix_y    = y_i + Y_BITS'(row_q) * Y_BITS'(size_eff) + Y_BITS'(sy_q);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            col_q  <= '0;
            row_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            draw_q <= 1'b0;
            fin_q  <= 1'b0;
        end else if (!enable_i) begin
            col_q  <= '0;
            row_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            draw_q <= 1'b0;
            fin_q  <= 1'b0;
        end else if (fin_q) begin
            draw_q <= 1'b0;
        end else begin
            x_q    <= pix_x;
            y_q    <= pix_y;
            draw_q <= pix_on;
            if (!sx_last) begin
                sx_q <= sx_q + ATTR_BITS'(1);
            end else begin
                sx_q <= '0;
                if (!col_last) begin
                    col_q <= col_q + 3'd1;
                end else begin
                    col_q <= '0;
                    if (!sy_last) begin
                        sy_q <= sy_q + ATTR_BITS'(1);
                    end else begin
                        sy_q <= '0;
                        if (!row_last) begin
                            row_q <= row_q + 3'd1;
                        end else begin
                            row_q <= '0;
                            fin_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign out_x_o        = x_q;
    assign out_y_o        = y_q;
    assign is_drawing_o   = draw_q;
    assign has_finished_o = fin_q;

endmodule

// File: rtl/text_renderer.sv
// String layout controller: fetches characters from a synchronous text buffer,
// tracks the cursor with wrap/newline handling and drives one glyph engine.
module text_renderer
    import text_renderer_pkg::*;
#(
    parameter int ADDR_BITS    = 6,
    parameter int CHAR_SPACING = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] length_i,
    input  logic [X_BITS-1:0]    origin_x_i,
    input  logic [Y_BITS-1:0]    origin_y_i,
    input  logic [ATTR_BITS-1:0] size_i,
    input  logic [X_BITS-1:0]    max_x_i,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    input  logic [CHAR_BITS-1:0] rd_data_i,
    output logic [X_BITS-1:0]    out_x_o,
    output logic [Y_BITS-1:0]    out_y_o,
    output logic                 is_drawing_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e               state_q;
    logic [ADDR_BITS-1:0] index_q, length_q, rd_addr_q;
    logic [X_BITS-1:0]    origin_x_q, max_x_q, cursor_x_q;
    logic [Y_BITS-1:0]    cursor_y_q;
    logic [ATTR_BITS-1:0] size_q;
    logic [CHAR_BITS-1:0] char_q;
    logic                 step_q, glyph_en_q, busy_q, done_q;

    logic [ADDR_BITS-1:0] index_next;
    logic [X_BITS-1:0]    x_step, glyph_w;
    logic [Y_BITS-1:0]    line_step;
    logic [X_BITS:0]      glyph_right;
    logic                 wrap_needed;
    logic                 glyph_drawing, glyph_finished;

    assign index_next  = index_q + ADDR_BITS'(1);
    assign x_step      = X_BITS'(size_q) * X_BITS'(FONT_WIDTH + CHAR_SPACING);
    assign glyph_w     = X_BITS'(size_q) * X_BITS'(FONT_WIDTH);
    assign line_step   = Y_BITS'(size_q) * Y_BITS'(FONT_HEIGHT + CHAR_SPACING);
    // Extra bit keeps the right-edge test honest when cursor + width overflows X_BITS.
    assign glyph_right = {1'b0, cursor_x_q} + {1'b0, glyph_w};
    assign wrap_needed = (glyph_right > {1'b0, max_x_q}) && (cursor_x_q != origin_x_q);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            length_q   <= '0;
            rd_addr_q  <= '0;
            origin_x_q <= '0;
            max_x_q    <= '0;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            size_q     <= '0;
            char_q     <= '0;
            step_q     <= 1'b0;
            glyph_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        length_q   <= length_i;
                        origin_x_q <= origin_x_i;
                        max_x_q    <= max_x_i;
                        size_q     <= size_i;
                        cursor_x_q <= origin_x_i;
                        cursor_y_q <= origin_y_i;
                        index_q    <= '0;
                        busy_q     <= 1'b1;
                        if (length_i == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            rd_addr_q <= '0;
                            state_q   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    char_q <= rd_data_i;
                    if (rd_data_i == CHAR_NEWLINE) begin
                        cursor_x_q <= origin_x_q;
                        cursor_y_q <= cursor_y_q + line_step;
                        step_q     <= 1'b0;
                        state_q    <= ST_ADVANCE;
                    end else if (rd_data_i == CHAR_SPACE) begin
                        step_q  <= 1'b1;
                        state_q <= ST_ADVANCE;
                    end else begin
                        if (wrap_needed) begin
                            cursor_x_q <= origin_x_q;
                            cursor_y_q <= cursor_y_q + line_step;
                        end
                        step_q     <= 1'b1;
                        glyph_en_q <= 1'b1;
                        state_q    <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (glyph_finished) begin
                        glyph_en_q <= 1'b0;
                        state_q    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (step_q) begin
                        cursor_x_q <= cursor_x_q + x_step;
                    end
                    index_q <= index_next;
                    if (index_next == length_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        rd_addr_q <= index_next;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    glyph_en_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    character_renderer u_char (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .enable_i      (glyph_en_q),
        .char_i        (char_q),
        .x_i           (cursor_x_q),
        .y_i           (cursor_y_q),
        .size_i        (size_q),
        .out_x_o       (out_x_o),
        .out_y_o       (out_y_o),
        .is_drawing_o  (glyph_drawing),
        .has_finished_o(glyph_finished)
    );

    assign is_drawing_o = glyph_drawing && (state_q == ST_DRAW);
    assign rd_addr_o    = rd_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameter ADDR_BITS, default 6: width of text-buffer address and length (strings up to 63 chars).
REQ-002 Parameter CHAR_SPACING, default 1: horizontal and vertical gap between glyph cells, in font pixels.
REQ-003 clock  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to render a string; ignored while busy=1.
REQ-006 length  input  ADDR_BITS  character count; latched on accepted start.
REQ-007 origin_x / origin_y  input  `X_BITES / `Y_BITES  top-left of first glyph; latched on start.
REQ-008 size  input  `ATTRIBUTE_VAL_BITES  pixel scale; latched on start.
REQ-009 max_x  input  `X_BITES  right wrap boundary (exclusive); latched on start.
REQ-010 rd_addr  output  ADDR_BITS  text-buffer read address.
REQ-011 rd_data  input  `CHAR_BITES  buffer data, valid one cycle after rd_addr (synchronous read).
REQ-012 out_x / out_y  output  `X_BITES / `Y_BITES  pixel coordinate from the glyph renderer, passed through.
REQ-013 is_drawing  output  1  high only while out_x/out_y is a pixel to plot.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse when the string is complete.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT_DATA, DRAW, RELEASE, ADVANCE, DONE.
REQ-017 IDLE: start=1 latches inputs, sets index=0, cursor=(origin_x,origin_y), goes to FETCH; length=0 goes straight to DONE.
REQ-018 FETCH: drive rd_addr=index; next WAIT_DATA. WAIT_DATA: capture rd_data into char register.
REQ-019 WAIT_DATA decode: 8'h0A (newline) -> cursor_x=line origin, cursor_y += size*(`FONT_HEIGHT+CHAR_SPACING), go ADVANCE without drawing.
REQ-020 8'h20 (space) -> go ADVANCE without drawing (cursor still steps).
REQ-021 Other chars: if cursor_x + size*`FONT_WIDTH > max_x and cursor_x != line origin, wrap first (as newline), then enter DRAW.
REQ-022 DRAW: glyph renderer enable high with char, cursor, size; stay until its has_finished=1.
REQ-023 RELEASE: enable low exactly one cycle so the glyph renderer clears its pixel index; then ADVANCE.
REQ-024 ADVANCE: after a drawn char or space, cursor_x += size*(`FONT_WIDTH+CHAR_SPACING); index++; index==length -> DONE, else FETCH.
REQ-025 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-026 Cursor arithmetic truncates to `X_BITES/`Y_BITES (wrap modulo 2^N); no saturation, no vertical clipping.
REQ-027 is_drawing = glyph renderer is_drawing AND state==DRAW; low in all other states.
REQ-028 start asserted while busy is dropped, never queued.
REQ-029 Per-char overhead outside DRAW: 4 cycles (FETCH, WAIT_DATA, RELEASE, ADVANCE); skipped chars: 3.

Reset
REQ-030 reset=1 forces IDLE, index=0, rd_addr=0, busy=0, done=0, is_drawing=0, glyph enable=0, cursor=0, immediately and asynchronously.
REQ-031 Reset mid-string abandons the string; first rising clock after release sees IDLE and glyph enable low, clearing the glyph renderer.

Structure
REQ-032 `FONT_WIDTH, `FONT_HEIGHT, `CHAR_BITES, `X_BITES, `Y_BITES, `ATTRIBUTE_VAL_BITES, newline/space codes and state encodings live in the shared defines file.
REQ-033 Exactly one sub-module: character_renderer, instanced once; no other hierarchy.

Verification
REQ-034 length=0, start=1 -> done pulses 2 cycles later, is_drawing never high, rd_addr unchanged.
REQ-035 "A" at (10,20), size=1 -> only pixels in x 10..10+`FONT_WIDTH-1, y 20..; done once; busy low after.
REQ-036 "AB", size=2, CHAR_SPACING=1 -> second glyph origin x = 10+2*(`FONT_WIDTH+1).
REQ-037 "A\nB" -> B origin = (10, 20+size*(`FONT_HEIGHT+1)); no pixels for 8'h0A.
REQ-038 max_x=origin_x+2*size*(`FONT_WIDTH+1), "ABC" -> C wraps to (origin_x, next line).
REQ-039 reset pulse mid-DRAW -> all outputs 0 same cycle; new start renders correctly from index 0.
